// File: rtl/pipeline_credit_sink_mem.sv
// Beat storage for the credit sink: ENTRIES x WIDTH, one synchronous
// write port, one asynchronous read port, contents not reset.
module pipeline_credit_sink_mem #(
  parameter int WIDTH   = 1,
  parameter int ENTRIES = 4,
  localparam int PTR_W  = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [ENTRIES];

  // Write the accepted beat into its slot.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Head is read combinationally so the output falls through with no extra stage.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pipeline_credit_sink.sv
// Receive side of a credit-controlled link: buffers beats from a
// non-stallable delay line, presents them first-word-fall-through and
// returns one credit per dequeued beat.
module pipeline_credit_sink #(
  parameter int WIDTH   = 1,
  parameter int ENTRIES = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         out_ready,
  output logic                         credit_return,
  output logic [$clog2(ENTRIES+1)-1:0] count,
  output logic                         overflow
);

  localparam int PTR_W = $clog2(ENTRIES);
  localparam int CNT_W = $clog2(ENTRIES + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(ENTRIES - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ENTRIES);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_nxt;
  logic             full;
  logic             deq;
  logic             enq;
  logic             drop;

  // Pointers wrap explicitly so non-power-of-two depths never alias.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign out_valid = (count != '0);
  assign full      = (count == FULL_CNT);
  assign deq       = out_valid && out_ready;
  // A full buffer still accepts when the head leaves in the same cycle.
  assign enq       = in_valid && (!full || deq);
  assign drop      = in_valid && full && !deq;

  // Occupancy update from the enqueue/dequeue pair.
  always_comb begin
    count_nxt = count;
    unique case ({enq, deq})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // Control state: pointers, occupancy, sticky overflow and the registered credit pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      overflow      <= 1'b0;
      credit_return <= 1'b0;
    end else begin
      if (enq) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (deq) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count         <= count_nxt;
      credit_return <= deq;
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  pipeline_credit_sink_mem #(
    .WIDTH   (WIDTH),
    .ENTRIES (ENTRIES)
  ) u_mem (
    .clk     (clk),
    .wr_en   (enq),
    .wr_addr (wr_ptr),
    .wr_data (in_data),
    .rd_addr (rd_ptr),
    .rd_data (out_data)
  );

endmodule

// File: tb/tb_pipeline_credit_sink.sv
// Bench for pipeline_credit_sink: a 4-entry and a 3-entry instance,
// scoreboard queues filled by stimulus and drained by output monitors.
module tb_pipeline_credit_sink;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  logic       a_in_valid = 1'b0;
  logic [7:0] a_in_data = '0;
  logic       a_out_valid;
  logic [7:0] a_out_data;
  logic       a_out_ready = 1'b0;
  logic       a_credit;
  logic [2:0] a_count;
  logic       a_overflow;

  logic       b_in_valid = 1'b0;
  logic [7:0] b_in_data = '0;
  logic       b_out_valid;
  logic [7:0] b_out_data;
  logic       b_out_ready = 1'b0;
  logic       b_credit;
  logic [1:0] b_count;
  logic       b_overflow;

  int checks = 0;
  int errors = 0;
  int a_credits = 0;
  int b_credits = 0;
  logic [7:0] qa [$];
  logic [7:0] qb [$];

  always #5 clk = ~clk;

  pipeline_credit_sink #(.WIDTH(8), .ENTRIES(4)) dut_a (
    .clk           (clk),
    .resetn        (resetn),
    .in_valid      (a_in_valid),
    .in_data       (a_in_data),
    .out_valid     (a_out_valid),
    .out_data      (a_out_data),
    .out_ready     (a_out_ready),
    .credit_return (a_credit),
    .count         (a_count),
    .overflow      (a_overflow)
  );

  pipeline_credit_sink #(.WIDTH(8), .ENTRIES(3)) dut_b (
    .clk           (clk),
    .resetn        (resetn),
    .in_valid      (b_in_valid),
    .in_data       (b_in_data),
    .out_valid     (b_out_valid),
    .out_data      (b_out_data),
    .out_ready     (b_out_ready),
    .credit_return (b_credit),
    .count         (b_count),
    .overflow      (b_overflow)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Output monitors: every beat accepted by the consumer must match the queue head.
  always @(negedge clk) begin
    if (resetn && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_data unexpected beat actual=%0d required=none", a_out_data);
      end else begin
        chk("a_data", int'(a_out_data), int'(qa.pop_front()));
      end
    end
    if (resetn && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_data unexpected beat actual=%0d required=none", b_out_data);
      end else begin
        chk("b_data", int'(b_out_data), int'(qb.pop_front()));
      end
    end
    if (resetn && a_credit) a_credits++;
    if (resetn && b_credit) b_credits++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int cred;
    int sent;

    // Reset state, no clock edge needed.
    #1;
    chk("rst_count", int'(a_count), 0);
    chk("rst_valid", int'(a_out_valid), 0);
    chk("rst_credit", int'(a_credit), 0);
    chk("rst_overflow", int'(a_overflow), 0);
    @(negedge clk);
    resetn = 1'b1;

    // Single beat into empty buffer, consumer ready.
    @(posedge clk); #1;
    a_in_valid = 1'b1; a_in_data = 8'hA5; a_out_ready = 1'b1; qa.push_back(8'hA5);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    chk("t1_valid", int'(a_out_valid), 1);
    chk("t1_count1", int'(a_count), 1);
    chk("t1_credit_lo", int'(a_credit), 0);
    @(posedge clk); #1;
    chk("t1_credit_hi", int'(a_credit), 1);
    chk("t1_count0", int'(a_count), 0);
    chk("t1_valid0", int'(a_out_valid), 0);
    @(posedge clk); #1;
    chk("t1_credit_end", int'(a_credit), 0);
    a_out_ready = 1'b0;

    // Fill to 4, fifth beat overflows, then drain.
    c0 = a_credits;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      a_in_valid = 1'b1; a_in_data = 8'(i); qa.push_back(8'(i));
    end
    @(posedge clk); #1;
    chk("t2_count4", int'(a_count), 4);
    chk("t2_no_ovf", int'(a_overflow), 0);
    a_in_data = 8'd5;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    chk("t2_ovf", int'(a_overflow), 1);
    chk("t2_count_held", int'(a_count), 4);
    a_out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    a_out_ready = 1'b0;
    chk("t2_drained", int'(a_count), 0);
    @(posedge clk); #1;
    chk("t2_credits", a_credits - c0, 4);
    chk("t2_ovf_sticky", int'(a_overflow), 1);

    // Two beats buffered, then asynchronous reset mid-cycle.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      a_in_valid = 1'b1; a_in_data = 8'(8'h77 + i); qa.push_back(8'(8'h77 + i));
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    chk("t5_count2", int'(a_count), 2);
    c0 = a_credits;
    @(negedge clk); #2;
    resetn = 1'b0;
    #1;
    chk("t5_count", int'(a_count), 0);
    chk("t5_valid", int'(a_out_valid), 0);
    chk("t5_ovf", int'(a_overflow), 0);
    chk("t5_credit", int'(a_credit), 0);
    qa.delete();
    a_in_valid = 1'b1; a_out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t5_ignored", int'(a_count), 0);
    a_in_valid = 1'b0; a_out_ready = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("t5_no_credit", a_credits - c0, 0);

    // Full buffer with simultaneous enqueue and dequeue for 6 cycles.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      a_in_valid = 1'b1; a_in_data = 8'(8'h10 + i); qa.push_back(8'(8'h10 + i));
    end
    @(posedge clk); #1;
    c0 = a_credits;
    for (int i = 0; i < 6; i++) begin
      a_in_valid = 1'b1; a_out_ready = 1'b1;
      a_in_data = 8'(8'h20 + i); qa.push_back(8'(8'h20 + i));
      @(negedge clk);
      chk("t3_count4", int'(a_count), 4);
      chk("t3_no_ovf", int'(a_overflow), 0);
      if (i > 0) chk("t3_credit_run", int'(a_credit), 1);
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    chk("t3_credit_last", int'(a_credit), 1);
    for (int k = 0; k < 20 && a_out_valid; k++) begin
      @(posedge clk); #1;
    end
    a_out_ready = 1'b0;
    chk("t3_drain_count", int'(a_count), 0);
    @(posedge clk); #1;
    chk("t3_credits", a_credits - c0, 10);
    chk("t3_queue_empty", qa.size(), 0);

    // ENTRIES=3: credit-limited sender streams 10 beats, random consumer.
    cred = 3;
    sent = 0;
    for (int cyc = 0; cyc < 300 && (sent < 10 || b_out_valid || cred != 3); cyc++) begin
      @(posedge clk); #1;
      if (b_credit) cred++;
      if (sent < 10 && cred > 0) begin
        b_in_valid = 1'b1; b_in_data = 8'(8'h30 + sent); qb.push_back(8'(8'h30 + sent));
        sent++;
        cred--;
      end else begin
        b_in_valid = 1'b0;
      end
      b_out_ready = (sent < 10) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    b_in_valid = 1'b0;
    b_out_ready = 1'b0;
    @(posedge clk); #1;
    chk("t4_sent", sent, 10);
    chk("t4_credits", b_credits, 10);
    chk("t4_count", int'(b_count), 0);
    chk("t4_no_ovf", int'(b_overflow), 0);
    chk("t4_queue_empty", qb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_credit_sink.md
PIPELINE_CREDIT_SINK -- requirements
Module: pipeline_credit_sink

Interface
REQ-001 SHALL have parameter WIDTH, default 1, data width in bits (>=1).
REQ-002 SHALL have parameter ENTRIES, default 4, buffer depth and initial sender credit count (>=2, need not be power of 2).
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  1  beat arriving from far end of a non-stallable delay line.
REQ-006 SHALL have port in_data  input  WIDTH  beat payload, qualified by in_valid.
REQ-007 SHALL have port out_valid  output  1  buffer head holds a beat.
REQ-008 SHALL have port out_data  output  WIDTH  head payload, meaningful only when out_valid=1.
REQ-009 SHALL have port out_ready  input  1  consumer accepts head this cycle.
REQ-010 SHALL have port credit_return  output  1  one-cycle pulse, one credit back to sender per dequeued beat.
REQ-011 SHALL have port count  output  $clog2(ENTRIES+1)  current occupancy.
REQ-012 SHALL have port overflow  output  1  sticky error: beat arrived with no free entry.

Function
REQ-013 SHALL enqueue in_data every cycle in_valid=1 and a slot is free; no ready is offered upstream (credit flow control only).
REQ-014 SHALL present first-word-fall-through output: out_valid = (count!=0), out_data = entry at read pointer, no extra register stage.
REQ-015 SHALL give latency of 1 cycle: in_valid at edge N into empty buffer -> out_valid=1 after edge N.
REQ-016 SHALL dequeue exactly when out_valid && out_ready; out_ready with out_valid=0 has no effect.
REQ-017 SHALL, on simultaneous enqueue and dequeue, leave count unchanged, including when full (ENTRIES) -- accepted, no overflow.
REQ-018 SHALL, on in_valid with count=ENTRIES and no dequeue same cycle, drop the beat, keep buffer contents unchanged, and set overflow=1 until reset.
REQ-019 SHALL wrap read and write pointers from ENTRIES-1 to 0; arbitrary ENTRIES supported without aliasing.
REQ-020 SHALL register credit_return: dequeue at edge N -> credit_return=1 for the cycle after edge N; back-to-back dequeues -> credit_return held high, one credit per cycle.
REQ-021 SHALL keep count equal to enqueues minus dequeues since reset, never exceeding ENTRIES nor below 0.
REQ-022 SHALL keep out_data stable while out_valid=1 and out_ready=0.

Reset
REQ-023 SHALL, on resetn=0, asynchronously clear pointers, count=0, out_valid=0, credit_return=0, overflow=0; storage contents unreset.
REQ-024 SHALL discard buffered beats on reset mid-operation with no credit_return pulses for them; sender is reset concurrently and restores ENTRIES credits.
REQ-025 SHALL ignore in_valid and out_ready while resetn=0 and resume on the first edge after deassertion.

Structure
REQ-026 SHALL need no shared package; WIDTH, ENTRIES, and pointer width ($clog2(ENTRIES)) are local parameters/localparams.
REQ-027 SHALL place storage in one sub-module pipeline_credit_sink_mem (ENTRIES x WIDTH, one write port, one async read port, no reset), control logic in the top.

Verification
REQ-028 SHALL cover: ENTRIES=4, 1 beat 0xA5 into empty, out_ready=1 -> out_valid after 1 edge with 0xA5, credit_return pulse next cycle, count 1->0.
REQ-029 SHALL cover: out_ready=0, 4 beats 1..4 -> count=4, overflow=0; 5th beat 5 -> overflow=1, then drain yields 1,2,3,4 and 4 credit pulses.
REQ-030 SHALL cover: full buffer, in_valid and out_ready both 1 for 6 cycles -> count stays 4, overflow=0, 6 consecutive credit_return cycles, order preserved.
REQ-031 SHALL cover: ENTRIES=3, stream 10 beats with random out_ready -> pointers wrap, output sequence equals input, credits total 10.
REQ-032 SHALL cover: resetn pulled low asynchronously mid-cycle with count=2 -> count=0, out_valid=0, overflow=0, credit_return=0 immediately, no clock needed.
